// File: rtl/toggle_event_rx_pkg.sv
// Shared constants for the toggle event link (transmitter and receiver).
package toggle_event_rx_pkg;

  localparam int SYNC_STAGES_MIN     = 2;
  localparam int SYNC_STAGES_MAX     = 4;
  localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/toggle_event_rx_sync.sv
// N-stage synchronizer for the incoming toggle line; output is the last stage.
module toggle_sync
  import toggle_event_rx_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic async_reset_n,
  input  logic d,
  output logic q
);

  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("toggle_sync: STAGES out of range");
  end

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/toggle_event_rx.sv
// Toggle-line event decoder: edge pulse, valid/ready flag, saturating count, sticky overrun.
module toggle_event_rx
  import toggle_event_rx_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             async_reset_n,
  input  logic             t_in,
  input  logic             ev_ready,
  input  logic             clr,
  output logic             level,
  output logic             ev_pulse,
  output logic             ev_valid,
  output logic             overrun,
  output logic [CNT_W-1:0] ev_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic prev;
  logic edge_det;
  logic ovr_cond;

  toggle_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .d             (t_in),
    .q             (level)
  );

  assign edge_det = level ^ prev;
  assign ovr_cond = edge_det && ev_valid && !ev_ready;

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      prev     <= 1'b0;
      ev_pulse <= 1'b0;
      ev_valid <= 1'b0;
      overrun  <= 1'b0;
      ev_count <= '0;
    end else begin
      prev     <= level;
      ev_pulse <= edge_det;

      // A new edge wins over an acceptance in the same cycle.
      if (edge_det) begin
        ev_valid <= 1'b1;
      end else if (ev_ready) begin
        ev_valid <= 1'b0;
      end

      // clr takes effect first, then the same cycle's event is applied on top.
      if (clr) begin
        overrun  <= ovr_cond;
        ev_count <= edge_det ? CNT_W'(1) : '0;
      end else begin
        if (ovr_cond) begin
          overrun <= 1'b1;
        end
        if (edge_det && ev_count != CNT_MAX) begin
          ev_count <= ev_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_toggle_event_rx.sv
// Scoreboard bench for toggle_event_rx: CNT_W=8 and CNT_W=3 instances share stimulus.
module tb_toggle_event_rx;

  logic       clk = 1'b0;
  logic       async_reset_n = 1'b0;
  logic       t_in = 1'b0;
  logic       ev_ready = 1'b0;
  logic       clr = 1'b0;

  logic       level8, pulse8, valid8, ovr8;
  logic [7:0] cnt8;
  logic       level3, pulse3, valid3, ovr3;
  logic [2:0] cnt3;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic rdy_s = 1'b0, clr_s = 1'b0, rst_s = 1'b0;

  typedef struct {int at; logic val;} lvl_t;
  int   exp_q[$];
  lvl_t lvl_q[$];

  // behavioural model state
  logic m_valid, m_ovr, m_level;
  int   m_cnt8, m_cnt3;

  toggle_event_rx #(.SYNC_STAGES(2), .CNT_W(8)) dut8 (
    .clk(clk), .async_reset_n(async_reset_n), .t_in(t_in), .ev_ready(ev_ready), .clr(clr),
    .level(level8), .ev_pulse(pulse8), .ev_valid(valid8), .overrun(ovr8), .ev_count(cnt8)
  );

  toggle_event_rx #(.SYNC_STAGES(2), .CNT_W(3)) dut3 (
    .clk(clk), .async_reset_n(async_reset_n), .t_in(t_in), .ev_ready(ev_ready), .clr(clr),
    .level(level3), .ev_pulse(pulse3), .ev_valid(valid3), .overrun(ovr3), .ev_count(cnt3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rdy_s <= ev_ready;
    clr_s <= clr;
    rst_s <= async_reset_n;
  end

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // Monitor: applies the event rules to the model for the edge just past, then compares.
  always @(negedge clk) begin
    logic ev, ovr_cond;
    if (!rst_s) begin
      m_valid = 1'b0; m_ovr = 1'b0; m_level = 1'b0; m_cnt8 = 0; m_cnt3 = 0;
    end else begin
      ev = 1'b0;
      while (exp_q.size() > 0 && exp_q[0] < cyc) begin
        chk("missed_event", 0, 1);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0] == cyc) begin
        ev = 1'b1;
        void'(exp_q.pop_front());
      end
      if (lvl_q.size() > 0 && lvl_q[0].at == cyc) begin
        m_level = lvl_q[0].val;
        void'(lvl_q.pop_front());
      end
      ovr_cond = ev && m_valid && !rdy_s;
      if (clr_s) begin
        m_cnt8 = ev ? 1 : 0;
        m_cnt3 = ev ? 1 : 0;
        m_ovr  = ovr_cond;
      end else begin
        if (ev) begin
          m_cnt8 = sat_inc(m_cnt8, 255);
          m_cnt3 = sat_inc(m_cnt3, 7);
        end
        m_ovr = m_ovr | ovr_cond;
      end
      if (ev) m_valid = 1'b1;
      else if (rdy_s) m_valid = 1'b0;

      if (pulse8 || ev) chk("pulse8", int'(pulse8), int'(ev));
      if (pulse3 || ev) chk("pulse3", int'(pulse3), int'(ev));
      chk("level8", int'(level8), int'(m_level));
      chk("level3", int'(level3), int'(m_level));
      chk("valid8", int'(valid8), int'(m_valid));
      chk("valid3", int'(valid3), int'(m_valid));
      chk("overrun8", int'(ovr8), int'(m_ovr));
      chk("overrun3", int'(ovr3), int'(m_ovr));
      chk("count8", int'(cnt8), m_cnt8);
      chk("count3", int'(cnt3), m_cnt3);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Change t_in between edges: captured next edge, level two edges on, pulse three.
  task automatic toggle();
    t_in = ~t_in;
    exp_q.push_back(cyc + 3);
    lvl_q.push_back('{at: cyc + 2, val: t_in});
  endtask

  task automatic release_reset();
    async_reset_n = 1'b1;
    if (t_in) begin
      exp_q.push_back(cyc + 3);
      lvl_q.push_back('{at: cyc + 2, val: 1'b1});
    end
  endtask

  task automatic check_all_zero();
    chk("reset_zero8", int'({level8, pulse8, valid8, ovr8, cnt8}), 0);
    chk("reset_zero3", int'({level3, pulse3, valid3, ovr3, cnt3}), 0);
  endtask

  initial begin
    int gap;
    step(3);
    check_all_zero();
    release_reset();
    step(3);

    // single event, consumer always ready
    ev_ready = 1'b1;
    toggle();
    step(6);

    // pending then overrun, then a one-cycle accept
    ev_ready = 1'b0;
    toggle();
    step(4);
    toggle();
    step(5);
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
    step(3);

    // accept on the same edge as a new event
    clr = 1'b1; step(1); clr = 1'b0;
    toggle();
    step(5);
    toggle();
    step(2);
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
    step(3);
    ev_ready = 1'b1;
    step(2);

    // saturation of the narrow counter, then clr coincident with an event
    clr = 1'b1; step(1); clr = 1'b0;
    repeat (9) begin
      toggle();
      step(4);
    end
    step(2);
    toggle();
    step(2);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(4);

    // reset mid-operation with an event pending and count 5
    clr = 1'b1; step(1); clr = 1'b0;
    repeat (4) begin
      toggle();
      step(4);
    end
    ev_ready = 1'b0;
    toggle();
    step(5);
    async_reset_n = 1'b0;
    exp_q.delete();
    lvl_q.delete();
    #1;
    check_all_zero();
    t_in = 1'b1;
    step(3);
    release_reset();
    ev_ready = 1'b1;
    step(6);

    // falling transition
    toggle();
    step(6);

    // randomized traffic
    gap = 4;
    for (int i = 0; i < 600; i++) begin
      ev_ready = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 39) == 0);
      gap--;
      if (gap == 0) begin
        toggle();
        gap = $urandom_range(3, 9);
      end
      step(1);
    end
    clr = 1'b0;
    ev_ready = 1'b1;
    step(8);
    chk("events_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
